// File: rtl/intr_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : intr_pkg
// Purpose  : Shared types, constants and helpers for the RAT interrupt
//            controller.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
package intr_pkg;

   // Largest number of request lines the controller is built for
   localparam int MAX_SRC = 16;

   // Controller sequencing: waiting, request raised, handler running
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } intr_state_t;

   // Width of a source index, never narrower than one bit
   function automatic int id_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/intr_sync_edge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : intr_sync_edge
// Purpose  : One interrupt source: input synchroniser, previous-value flop
//            and pending latch (rising-edge latched or level-following).
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module intr_sync_edge
   import intr_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter bit EDGE        = 1'b1
) (
   input  logic clk,
   input  logic RST,
   input  logic irq,
   input  logic clr,
   output logic pend
);

   logic w_synced;
   logic r_prev;
   logic r_pend;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_synced = irq;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] r_sync;

         // Shift the raw line through the synchroniser chain
         always_ff @(posedge clk) begin
            if (RST) begin
               r_sync <= '0;
            end else begin
               r_sync[0] <= irq;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  r_sync[i] <= r_sync[i-1];
               end
            end
         end

         assign w_synced = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   // Edge sources latch a new rising edge, which wins over a same-cycle clear;
   // level sources simply follow the synchronised line
   always_ff @(posedge clk) begin
      if (RST) begin
         r_prev <= 1'b0;
         r_pend <= 1'b0;
      end else begin
         r_prev <= w_synced;
         r_pend <= EDGE ? ((w_synced & ~r_prev) | (r_pend & ~clr)) : w_synced;
      end
   end

   assign pend = r_pend;

endmodule
`default_nettype wire

// File: rtl/intr_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : intr_ctrl
// Purpose  : Prioritised interrupt controller for the RAT MCU. Masks pending
//            sources, raises one request to the control unit, saves/clears
//            the global enable on acknowledge and restores it on RETI.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module intr_ctrl
   import intr_pkg::*;
#(
   parameter int               N_SRC       = 4,
   parameter int               SYNC_STAGES = 2,
   parameter logic [N_SRC-1:0] EDGE_MASK   = '1,
   parameter logic [N_SRC-1:0] MASK_RST    = '1
) (
   input  logic                       clk,
   input  logic                       RST,
   input  logic [N_SRC-1:0]           IRQ_IN,
   input  logic                       I_SET,
   input  logic                       I_CLR,
   input  logic                       MASK_WE,
   input  logic [N_SRC-1:0]           MASK_DIN,
   input  logic                       INT_ACK,
   input  logic                       RETI,
   output logic                       I_FLAG_OUT,
   output logic                       INTR,
   output logic [id_width(N_SRC)-1:0] INT_ID,
   output logic [N_SRC-1:0]           PENDING,
   output logic [N_SRC-1:0]           MASK_OUT
);

   localparam int c_ID_W = id_width(N_SRC);

   logic [N_SRC-1:0]  w_pend;
   logic [N_SRC-1:0]  w_elig;
   logic [N_SRC-1:0]  w_clr;
   logic [N_SRC-1:0]  r_mask;
   logic [c_ID_W-1:0] w_win_id;
   logic [c_ID_W-1:0] r_int_id;
   logic              w_any;
   logic              w_ack_fire;
   logic              w_reti_fire;
   logic              w_cancel;
   logic              r_i_flag;
   logic              r_shadow;
   logic              r_intr;
   intr_state_t       r_state;

   // Only an ack taken while a request is outstanding clears the latched source
   assign w_ack_fire  = (r_state == REQ) && INT_ACK;
   assign w_reti_fire = (r_state == SERVICE) && RETI;
   // Request withdrawn when interrupts are disabled or its source gets masked
   assign w_cancel    = (r_state == REQ) && !INT_ACK && (I_CLR || !r_mask[r_int_id]);

   generate
      for (genvar g = 0; g < N_SRC; g++) begin : g_src
         assign w_clr[g] = w_ack_fire && (r_int_id == c_ID_W'(g));

         intr_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE        (EDGE_MASK[g])
         ) u_src (
            .clk  (clk),
            .RST  (RST),
            .irq  (IRQ_IN[g]),
            .clr  (w_clr[g]),
            .pend (w_pend[g])
         );
      end
   endgenerate

   assign w_elig = w_pend & r_mask;
   assign w_any  = |w_elig;

   // Lowest eligible index wins; scanning downwards leaves the lowest last
   always_comb begin
      w_win_id = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_win_id = c_ID_W'(i);
         end
      end
   end

   // Mask register, written by software
   always_ff @(posedge clk) begin
      if (RST) begin
         r_mask <= MASK_RST;
      end else if (MASK_WE) begin
         r_mask <= MASK_DIN;
      end
   end

   // Global enable and its shadow: CLI beats SEI beats RETI restore beats ack
   always_ff @(posedge clk) begin
      if (RST) begin
         r_i_flag <= 1'b0;
         r_shadow <= 1'b0;
      end else begin
         if (w_ack_fire) begin
            r_shadow <= r_i_flag;
         end
         if (I_CLR) begin
            r_i_flag <= 1'b0;
         end else if (I_SET) begin
            r_i_flag <= 1'b1;
         end else if (w_reti_fire) begin
            r_i_flag <= r_shadow;
         end else if (w_ack_fire) begin
            r_i_flag <= 1'b0;
         end
      end
   end

   // Request sequencer: raise, hold the latched ID, service without nesting
   always_ff @(posedge clk) begin
      if (RST) begin
         r_state  <= IDLE;
         r_intr   <= 1'b0;
         r_int_id <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_i_flag && w_any) begin
                  r_state  <= REQ;
                  r_intr   <= 1'b1;
                  r_int_id <= w_win_id;
               end
            end
            REQ: begin
               if (w_ack_fire) begin
                  r_intr  <= 1'b0;
                  r_state <= SERVICE;
               end else if (w_cancel) begin
                  r_intr  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            SERVICE: begin
               if (w_reti_fire) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_intr  <= 1'b0;
            end
         endcase
      end
   end

   assign I_FLAG_OUT = r_i_flag;
   assign INTR       = r_intr;
   assign INT_ID     = r_int_id;
   assign PENDING    = w_pend;
   assign MASK_OUT   = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_intr_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_intr_ctrl
// Purpose  : Directed bench for intr_ctrl; expected request IDs are queued
//            by the stimulus and checked by a monitor on each INTR rise.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_intr_ctrl;

   logic       clk = 1'b0;
   logic       RST;
   logic [3:0] IRQ_IN;
   logic       I_SET, I_CLR, MASK_WE, INT_ACK, RETI;
   logic [3:0] MASK_DIN;
   logic       I_FLAG_OUT, INTR;
   logic [1:0] INT_ID;
   logic [3:0] PENDING, MASK_OUT;

   int total = 0;
   int bad   = 0;
   int exp_q[$];
   logic prev_intr = 1'b0;

   intr_ctrl #(
      .N_SRC       (4),
      .SYNC_STAGES (2),
      .EDGE_MASK   (4'b1101),
      .MASK_RST    (4'b1111)
   ) dut (
      .clk        (clk),
      .RST        (RST),
      .IRQ_IN     (IRQ_IN),
      .I_SET      (I_SET),
      .I_CLR      (I_CLR),
      .MASK_WE    (MASK_WE),
      .MASK_DIN   (MASK_DIN),
      .INT_ACK    (INT_ACK),
      .RETI       (RETI),
      .I_FLAG_OUT (I_FLAG_OUT),
      .INTR       (INTR),
      .INT_ID     (INT_ID),
      .PENDING    (PENDING),
      .MASK_OUT   (MASK_OUT)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every new request must match the oldest queued expected ID
   always @(negedge clk) begin
      if (INTR === 1'b1 && prev_intr !== 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_intr: INT_ID=%0d, no request expected", INT_ID);
         end else begin
            int exp_id;
            exp_id = exp_q.pop_front();
            chk("intr_id", 32'(INT_ID), 32'(exp_id));
         end
      end
      prev_intr = INTR;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; IRQ_IN = '0; I_SET = 0; I_CLR = 0; MASK_WE = 0;
      MASK_DIN = '0; INT_ACK = 0; RETI = 0;
      step(2);
      chk("rst_iflag",   32'(I_FLAG_OUT), 32'(0));
      chk("rst_intr",    32'(INTR),       32'(0));
      chk("rst_id",      32'(INT_ID),     32'(0));
      chk("rst_pending", 32'(PENDING),    32'(0));
      chk("rst_mask",    32'(MASK_OUT),   32'hF);
      RST = 1'b0;

      // Basic request on source 2
      I_SET = 1; step(1); I_SET = 0;
      chk("sei", 32'(I_FLAG_OUT), 32'(1));
      exp_q.push_back(2);
      IRQ_IN = 4'b0100; step(1); IRQ_IN = '0; step(1);
      chk("basic_pend_early", 32'(PENDING), 32'(0));
      step(1);
      chk("basic_pend", 32'(PENDING), 32'h4);
      chk("basic_nointr_yet", 32'(INTR), 32'(0));
      step(1);
      chk("basic_intr", 32'(INTR), 32'(1));
      chk("basic_id", 32'(INT_ID), 32'(2));
      INT_ACK = 1; step(1); INT_ACK = 0;
      chk("ack_intr", 32'(INTR), 32'(0));
      chk("ack_iflag", 32'(I_FLAG_OUT), 32'(0));
      chk("ack_pend", 32'(PENDING), 32'(0));
      RETI = 1; step(1); RETI = 0;
      chk("reti_iflag", 32'(I_FLAG_OUT), 32'(1));

      // Priority: sources 3 (edge) and 1 (level) together
      exp_q.push_back(1); exp_q.push_back(3);
      IRQ_IN = 4'b1010; step(1); IRQ_IN = 4'b0010; step(3);
      chk("prio_intr", 32'(INTR), 32'(1));
      chk("prio_id", 32'(INT_ID), 32'(1));
      chk("prio_pend", 32'(PENDING), 32'hA);
      INT_ACK = 1; IRQ_IN = '0; step(1); INT_ACK = 0;
      step(4);
      chk("prio_pend_after", 32'(PENDING), 32'h8);
      chk("service_nonest", 32'(INTR), 32'(0));
      RETI = 1; step(1); RETI = 0;
      chk("prio_reti_edge", 32'(INTR), 32'(0));
      step(1);
      chk("prio_second_id", 32'(INT_ID), 32'(3));
      INT_ACK = 1; step(1); INT_ACK = 0;
      chk("prio_pend_clear", 32'(PENDING), 32'(0));
      RETI = 1; step(1); RETI = 0;

      // Masking source 0
      MASK_WE = 1; MASK_DIN = 4'b1110; step(1); MASK_WE = 0;
      chk("mask_out", 32'(MASK_OUT), 32'hE);
      IRQ_IN = 4'b0001; step(1); IRQ_IN = '0; step(4);
      chk("mask_pend", 32'(PENDING), 32'h1);
      chk("mask_nointr", 32'(INTR), 32'(0));
      exp_q.push_back(0);
      MASK_WE = 1; MASK_DIN = 4'b1111; step(1); MASK_WE = 0;
      chk("unmask_edge", 32'(INTR), 32'(0));
      step(1);
      chk("unmask_intr", 32'(INTR), 32'(1));
      chk("unmask_id", 32'(INT_ID), 32'(0));
      INT_ACK = 1; step(1); INT_ACK = 0;
      RETI = 1; step(1); RETI = 0;

      // CLI withdraws an unacknowledged request, pending kept
      exp_q.push_back(2); exp_q.push_back(2);
      IRQ_IN = 4'b0100; step(1); IRQ_IN = '0; step(3);
      chk("cancel_intr_up", 32'(INTR), 32'(1));
      I_CLR = 1; step(1); I_CLR = 0;
      chk("cancel_intr", 32'(INTR), 32'(0));
      chk("cancel_pend", 32'(PENDING), 32'h4);
      step(2);
      chk("cancel_stays_low", 32'(INTR), 32'(0));
      I_SET = 1; step(1); I_SET = 0; step(1);
      chk("rereq_intr", 32'(INTR), 32'(1));
      INT_ACK = 1; step(1); INT_ACK = 0;
      RETI = 1; step(1); RETI = 0;

      // Flag precedence
      I_CLR = 1; I_SET = 1; step(1); I_CLR = 0; I_SET = 0;
      chk("clr_beats_set", 32'(I_FLAG_OUT), 32'(0));
      I_SET = 1; step(1); I_SET = 0;
      exp_q.push_back(2);
      IRQ_IN = 4'b0100; step(1); IRQ_IN = '0; step(3);
      INT_ACK = 1; step(1); INT_ACK = 0;
      chk("svc_iflag", 32'(I_FLAG_OUT), 32'(0));
      RETI = 1; I_CLR = 1; step(1); RETI = 0; I_CLR = 0;
      chk("clr_beats_reti", 32'(I_FLAG_OUT), 32'(0));
      exp_q.push_back(3);
      I_SET = 1; step(1); I_SET = 0;
      IRQ_IN = 4'b1000; step(1); IRQ_IN = '0; step(3);
      chk("idle_after_reti", 32'(INTR), 32'(1));
      INT_ACK = 1; step(1); INT_ACK = 0;
      RETI = 1; step(1); RETI = 0;

      // Level source held through ack and RETI re-requests
      exp_q.push_back(1); exp_q.push_back(1);
      IRQ_IN = 4'b0010; step(4);
      chk("level_id", 32'(INT_ID), 32'(1));
      INT_ACK = 1; step(1); INT_ACK = 0; step(2);
      RETI = 1; step(1); RETI = 0;
      chk("level_reti_edge", 32'(INTR), 32'(0));
      step(1);
      chk("level_rereq", 32'(INTR), 32'(1));
      IRQ_IN = '0; INT_ACK = 1; step(1); INT_ACK = 0; step(5);
      RETI = 1; step(1); RETI = 0; step(3);
      chk("level_released", 32'(INTR), 32'(0));

      // Edge source held high requests once
      exp_q.push_back(2);
      IRQ_IN = 4'b0100; step(4);
      chk("edge_held_id", 32'(INT_ID), 32'(2));
      INT_ACK = 1; step(1); INT_ACK = 0; step(2);
      RETI = 1; step(1); RETI = 0; step(4);
      chk("edge_held_norereq", 32'(INTR), 32'(0));
      chk("edge_held_pend", 32'(PENDING), 32'(0));
      IRQ_IN = '0; step(3);

      // New edge on the acked source in the ack cycle is retained
      exp_q.push_back(2); exp_q.push_back(2);
      IRQ_IN = 4'b0100; step(1); IRQ_IN = '0; step(1);
      IRQ_IN = 4'b0100; step(1); IRQ_IN = '0; step(1);
      chk("setclr_intr", 32'(INTR), 32'(1));
      INT_ACK = 1; step(1); INT_ACK = 0;
      chk("setclr_pend", 32'(PENDING), 32'h4);
      step(2);
      RETI = 1; step(1); RETI = 0; step(1);
      chk("setclr_rereq", 32'(INTR), 32'(1));
      INT_ACK = 1; step(1); INT_ACK = 0;
      chk("setclr_cleared", 32'(PENDING), 32'(0));
      RETI = 1; step(1); RETI = 0;

      // Reset during service
      MASK_WE = 1; MASK_DIN = 4'b1100; step(1); MASK_WE = 0;
      exp_q.push_back(3);
      IRQ_IN = 4'b1000; step(1); IRQ_IN = '0; step(3);
      INT_ACK = 1; step(1); INT_ACK = 0;
      IRQ_IN = 4'b0100; step(1); IRQ_IN = '0; step(3);
      chk("pre_rst_pend", 32'(PENDING), 32'h4);
      chk("pre_rst_id", 32'(INT_ID), 32'(3));
      RST = 1; step(1);
      chk("mid_rst_iflag",   32'(I_FLAG_OUT), 32'(0));
      chk("mid_rst_intr",    32'(INTR),       32'(0));
      chk("mid_rst_id",      32'(INT_ID),     32'(0));
      chk("mid_rst_pending", 32'(PENDING),    32'(0));
      chk("mid_rst_mask",    32'(MASK_OUT),   32'hF);
      RST = 0;
      RETI = 1; step(1); RETI = 0;
      chk("reti_after_rst", 32'(I_FLAG_OUT), 32'(0));
      step(4);
      chk("no_intr_after_rst", 32'(INTR), 32'(0));

      step(3);
      chk("queue_drained", 32'(exp_q.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/intr_ctrl.md
# intr_ctrl

Parametrised interrupt controller for the RAT MCU, replacing the single set/clear interrupt-enable flip-flop with a full controller. Synchronises `N_SRC` external request lines, latches edge events, applies a per-source mask and the global interrupt-enable flag, and presents one prioritised request to the control unit through a request/acknowledge handshake. On acknowledge it saves and clears the global enable. `RETI` restores it.

## Interface
- `N_SRC`, 4: number of interrupt sources (1..16).
- `SYNC_STAGES`, 2: synchroniser flops per source (0 = input already synchronous).
- `EDGE_MASK`, all ones: per-source mode. 1 = rising-edge latched, 0 = level.
- `MASK_RST`, all ones: reset value of the mask register (1 = enabled).
- `clk` in 1: system clock, all state updates on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `IRQ_IN` in N_SRC: raw interrupt request lines.
- `I_SET` in 1: SEI, sets the global enable.
- `I_CLR` in 1: CLI, clears the global enable.
- `MASK_WE` in 1: writes `MASK_DIN` into the mask register.
- `MASK_DIN` in N_SRC: new mask value.
- `INT_ACK` in 1: control unit accepts the current request.
- `RETI` in 1: return from interrupt.
- `I_FLAG_OUT` out 1: global interrupt enable.
- `INTR` out 1: registered interrupt request to the control unit.
- `INT_ID` out clog2(N_SRC) (min 1): index of the requested/in-service source.
- `PENDING` out N_SRC: pending vector, before masking.
- `MASK_OUT` out N_SRC: current mask register.

## Operation
- **Per source:** synchroniser, then `prev` flop.
  - Edge mode: pending bit set on synced & ~prev. Cleared only by an `INT_ACK` selecting that source.
  - Level mode: pending = synced level. `INT_ACK` has no clearing effect.
- **Eligible vector:** PENDING & MASK_OUT. The lowest set index wins.
- **States:** IDLE, REQ, SERVICE.
- **IDLE:** if `I_FLAG_OUT` and eligible ≠ 0, go to REQ next edge. On that edge, `INTR`=1 and `INT_ID` = winner (latched).
- **REQ:**
  - `INT_ACK`: clear the pending bit of `INT_ID` (edge sources only), save I into the shadow, I←0, `INTR`←0, go to SERVICE.
  - `I_CLR`, or masking of the latched source, without ack: `INTR`←0, go to IDLE. The pending bit is kept.
  - `INT_ID` stays stable throughout REQ, even if a higher-priority source arrives.
- **SERVICE:** `INT_ID` held. No new request is raised (no nesting). On `RETI`: I←shadow, go to IDLE.
- **Global flag precedence (same cycle):** `I_CLR` > `I_SET` > `RETI` restore > ack clear.
- **Pending precedence:** if a new edge arrives on the source being acked in the same cycle, set beats clear, and the event is retained.
- `MASK_WE` takes effect on the next edge. `MASK_OUT` updates then.
- `INT_ACK` outside REQ and `RETI` outside SERVICE are ignored.
- `RST` mid-operation abandons any request or service and does not restore I.

## Timing
- **Reset values:** `I_FLAG_OUT`=0, `INTR`=0, `INT_ID`=0, `PENDING`=0, `MASK_OUT`=`MASK_RST`, shadow=0, state IDLE, synchroniser and `prev` flops 0.
  - A line already high at reset registers one edge after the synchroniser fills.
- **Latency:** edge k is the first edge sampling `IRQ_IN` high. Pending is visible after edge k+`SYNC_STAGES`. `INTR` rises one edge later, if eligible and I=1.
- **Ack:** `INTR` and I drop on the edge sampling `INT_ACK`=1.
- **RETI:** I restores on the edge sampling `RETI`=1. A new `INTR` can assert at the earliest on the following edge.
- **Minimum pulse width:** `IRQ_IN` must be held high at least 1 clk. Pulses narrower than that may be lost.

## Structure
- **Package `intr_pkg`:**
  - `intr_state_t` enum (IDLE, REQ, SERVICE).
  - Function `id_width(n)` = max(1, clog2(n)).
  - Constant `MAX_SRC` = 16.
- **Sub-module `intr_sync_edge`:** one source's synchroniser + `prev` flop + pending latch. Parameters: `SYNC_STAGES`, `EDGE`. Ports: `clk`, `RST`, `irq`, `clr`, `pend`. Generated `N_SRC` times.
- **Top:** priority encoder, mask register, global flag/shadow, and FSM.

## Test plan
- **Basic request:** `RST`, `I_SET`, pulse `IRQ_IN[2]` 1 cycle (N_SRC=4, SYNC_STAGES=2) → `PENDING[2]` after 2 edges, `INTR`=1 with `INT_ID`=2 one edge later. `INT_ACK` → `INTR`=0, `I_FLAG_OUT`=0, `PENDING[2]`=0.
- **Priority:** `IRQ_IN[3]` and `IRQ_IN[1]` rise together with I=1 → `INT_ID`=1. After `RETI`, the next request has `INT_ID`=3.
- **Masking:** `MASK_DIN`=4'b1110, pulse `IRQ_IN[0]` → `PENDING[0]`=1 but no `INTR`. Write mask 4'b1111 → `INTR` with `INT_ID`=0.
- **Precedence:**
  - `I_CLR` and `I_SET` in the same cycle → I=0.
  - `RETI` and `I_CLR` in the same cycle in SERVICE (shadow=1) → I=0, state IDLE.
- **Level vs edge:**
  - Level source (`EDGE_MASK[1]`=0) held high through ack and `RETI` → re-requests `INT_ID`=1 the edge after `RETI`.
  - Edge source held high → no re-request.
- **Reset and same-cycle set/clear:**
  - `RST` during SERVICE → all outputs at reset values, `I_FLAG_OUT`=0.
  - New edge on the acked source in the ack cycle → pending stays 1.
